// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI pad arbiter with forced CS-high gap between owners and a hold-limit preempt.
// Define SPI_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
module spi_bus_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_HOLD   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       done0,
    input  logic       done1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic [5:0] m0_spi_o,
    input  logic [5:0] m1_spi_o,
    output logic [1:0] m0_spi_i,
    output logic [1:0] m1_spi_i,
    output logic [5:0] spi_o,
    input  logic [1:0] spi_i,
    output logic       preempt
);

    // state | meaning
    // IDLE  | no owner, pads idle, arbitrate on next edge
    // OWN0  | requester 0 drives the pads
    // OWN1  | requester 1 drives the pads
    // GAP   | forced CS-high spacing, requests ignored
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    localparam logic [5:0] SPI_IDLE   = 6'b000001;
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt, hold_inc;
    logic [3:0] gap_cnt, gap_nxt;
    logic       preempt_nxt;
    logic       tie_to0;
    logic       pick0;

`ifdef SPI_ARB_RR_EN
    logic last_owner;

    // last_owner=1 means requester 1 was served last, so a tie goes to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (state_nxt == OWN0) begin
            last_owner <= 1'b0;
        end else if (state_nxt == OWN1) begin
            last_owner <= 1'b1;
        end
    end

    assign tie_to0 = last_owner;
`else
    assign tie_to0 = 1'b1;
`endif

    assign pick0    = req0 && (!req1 || tie_to0);
    // hold_inc is the number of owned cycles including the current one
    assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        gap_nxt     = gap_cnt;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = pick0 ? OWN0 : OWN1;
                    hold_nxt  = 8'd0;
                end
            end
            OWN0: begin
                hold_nxt = hold_inc;
                if (done0 || !req0) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end else if (hold_inc == HOLD_LIMIT && req1) begin
                    state_nxt   = GAP;
                    gap_nxt     = GAP_LOAD;
                    preempt_nxt = 1'b1;
                end
            end
            OWN1: begin
                hold_nxt = hold_inc;
                if (done1 || !req1) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end else if (hold_inc == HOLD_LIMIT && req0) begin
                    state_nxt   = GAP;
                    gap_nxt     = GAP_LOAD;
                    preempt_nxt = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            preempt  <= 1'b0;
            hold_cnt <= 8'd0;
            gap_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            gnt0     <= (state_nxt == OWN0);
            gnt1     <= (state_nxt == OWN1);
            preempt  <= preempt_nxt;
            hold_cnt <= hold_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

    // Pad mux keys off the grant flops so reset forces CS high without a clock
    always_comb begin
        spi_o = SPI_IDLE;
        if (gnt0) begin
            spi_o = m0_spi_o;
        end else if (gnt1) begin
            spi_o = m1_spi_o;
        end
    end

    assign m0_spi_i = gnt0 ? spi_i : 2'b00;
    assign m1_spi_i = gnt1 ? spi_i : 2'b00;

endmodule
